aes_mixcolumns_seq: RTL and testbench

- Iterative MixColumns controller. Time-multiplexes one 32-bit column mixer across the four columns of a 128-bit AES state, one column per cycle.
- Sits between ShiftRows and AddRoundKey in the area-optimised round pipeline.
- Uses valid/ready handshakes on both sides.
- A per-transfer bypass flag skips the mix for the final AES round.

---
 rtl/aes_pkg.sv | 9 +
 rtl/aes_mixword_min.sv | 15 +
 rtl/mixword.sv | 17 +
 rtl/aes_mixcolumns_seq.sv | 68 ++++++
 tb/tb_aes_mixcolumns_seq.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared types, sizes and GF(2^8) helper for the AES round datapath
package aes_pkg;
  typedef enum logic [1:0] {IDLE, MIX, DONE} mixseq_state_t;
  localparam int AES_NCOLS = 4;
  localparam int AES_COLW = 32;
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
endpackage

// File: rtl/aes_mixword_min.sv
// aes_mixword_min: MixColumns on one column sharing the all-byte XOR term
module aes_mixword_min
  import aes_pkg::*;
(
  input  logic [AES_COLW-1:0] in_col,
  output logic [AES_COLW-1:0] out_col
);
  logic [7:0] a0, a1, a2, a3, t;
  assign {a0, a1, a2, a3} = in_col;
  assign t = a0 ^ a1 ^ a2 ^ a3;
  assign out_col = {a0 ^ t ^ xtime(a0 ^ a1),
                    a1 ^ t ^ xtime(a1 ^ a2),
                    a2 ^ t ^ xtime(a2 ^ a3),
                    a3 ^ t ^ xtime(a3 ^ a0)};
endmodule

// File: rtl/mixword.sv
// mixword: MixColumns on one 32-bit column, written as explicit gm2/gm3 products
module mixword
  import aes_pkg::*;
(
  input  logic [AES_COLW-1:0] in_col,
  output logic [AES_COLW-1:0] out_col
);
  logic [7:0] a0, a1, a2, a3;
  function automatic logic [7:0] gm3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction
  assign {a0, a1, a2, a3} = in_col;
  assign out_col = {xtime(a0) ^ gm3(a1) ^ a2 ^ a3,
                    a0 ^ xtime(a1) ^ gm3(a2) ^ a3,
                    a0 ^ a1 ^ xtime(a2) ^ gm3(a3),
                    gm3(a0) ^ a1 ^ a2 ^ xtime(a3)};
endmodule

// File: rtl/aes_mixcolumns_seq.sv
// aes_mixcolumns_seq: iterative MixColumns, one column per cycle through a single mixer
module aes_mixcolumns_seq
  import aes_pkg::*;
#(
  parameter bit MIN_IMPL = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);
  mixseq_state_t state_q, state_d;
  logic [1:0] col_q, col_d;
  logic [127:0] src_q, src_d, out_data_q, out_data_d;
  logic out_valid_q, out_valid_d;
  logic [AES_COLW-1:0] mix_in, mix_out;
  logic accept;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      col_q <= 2'd0;
      src_q <= '0;
      out_data_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      src_q <= src_d;
      out_data_q <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end
  always_comb begin
    state_d = (state_q == IDLE) ? (accept ? (in_bypass ? DONE : MIX) : IDLE)
            : (state_q == MIX)  ? (col_q == 2'd3 ? DONE : MIX)
            : (out_valid_q && out_ready ? IDLE : DONE);
  end
  always_comb begin
    in_ready = (state_q == IDLE);
    busy = (state_q != IDLE);
  end
  // a bypassed state enters DONE one cycle before out_valid rises
  always_comb begin
    accept = in_valid && in_ready;
    col_d = (state_q == MIX) ? col_q + 2'd1 : 2'd0;
    src_d = accept ? in_data : src_q;
    mix_in = '0;
    for (int c = 0; c < AES_NCOLS; c++)
      if (col_q == 2'(c)) mix_in = src_q[(AES_NCOLS-1-c)*AES_COLW +: AES_COLW];
    out_data_d = (accept && in_bypass) ? in_data : out_data_q;
    for (int c = 0; c < AES_NCOLS; c++)
      if (state_q == MIX && col_q == 2'(c)) out_data_d[(AES_NCOLS-1-c)*AES_COLW +: AES_COLW] = mix_out;
    out_valid_d = (state_q == MIX && col_q == 2'd3) || (state_q == DONE && !(out_valid_q && out_ready));
  end
  if (MIN_IMPL) begin : g_min
    aes_mixword_min u_mix (.in_col(mix_in), .out_col(mix_out));
  end else begin : g_std
    mixword u_mix (.in_col(mix_in), .out_col(mix_out));
  end
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
endmodule

// File: tb/tb_aes_mixcolumns_seq.sv
// tb_aes_mixcolumns_seq: directed scoreboard bench driving both mixer variants in lockstep
module tb_aes_mixcolumns_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic in_bypass = 1'b0;
  logic out_ready = 1'b0;
  logic [127:0] in_data = '0;
  logic in_ready_a, out_valid_a, busy_a, in_ready_b, out_valid_b, busy_b;
  logic [127:0] out_data_a, out_data_b;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [127:0] q[$];
  always #5 clk = ~clk;
  aes_mixcolumns_seq #(.MIN_IMPL(1'b1)) dut_min (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .in_bypass(in_bypass), .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a), .busy(busy_a));
  aes_mixcolumns_seq #(.MIN_IMPL(1'b0)) dut_std (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .in_bypass(in_bypass), .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b), .busy(busy_b));
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  function automatic logic [127:0] model(input logic [127:0] d, input logic byp);
    logic [127:0] r;
    logic [7:0] a[4];
    logic [7:0] cf[4];
    logic [7:0] o;
    if (byp) return d;
    cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = d[127 - 32*c - 8*j -: 8];
      for (int k = 0; k < 4; k++) begin
        o = 8'h00;
        for (int j = 0; j < 4; j++) o = o ^ gmul(cf[(j - k + 4) % 4], a[j]);
        r[127 - 32*c - 8*k -: 8] = o;
      end
    end
    return r;
  endfunction
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step;
    logic [127:0] e;
    if (out_valid_a === 1'b1 && out_ready) begin
      chk("sb_nonempty", 128'(q.size() != 0), 128'd1);
      chk("out_valid_std", 128'(out_valid_b), 128'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("out_data_min", out_data_a, e);
        chk("out_data_std", out_data_b, e);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic wait_ready(input string tag);
    int t = 0;
    while (!in_ready_a && t < 50) begin step(); t++; end
    chk(tag, 128'(in_ready_a), 128'd1);
  endtask
  task automatic run(input logic [127:0] d, input logic byp, input logic [127:0] exp, input int exp_lat);
    int lat = 0;
    int nlow = 0;
    int nbusy = 0;
    in_data = d; in_bypass = byp; in_valid = 1'b1;
    wait_ready("accept_ready");
    step();
    in_valid = 1'b0;
    q.push_back(exp);
    while (!out_valid_a && lat < 20) begin
      if (!in_ready_a) nlow++;
      if (busy_a) nbusy++;
      step(); lat++;
    end
    if (!in_ready_a) nlow++;
    if (busy_a) nbusy++;
    chk("latency", 128'(lat), 128'(exp_lat));
    step();
    chk("in_ready_low_cycles", 128'(nlow), 128'(exp_lat + 1));
    chk("busy_cycles", 128'(nbusy), 128'(exp_lat + 1));
    chk("valid_drop", 128'(out_valid_a), 128'd0);
    chk("back_idle", 128'(in_ready_a), 128'd1);
  endtask
  initial begin
    logic [127:0] snap, vnew;
    logic [127:0] bb[3];
    int t, last;
    step(); step();
    chk("rst_in_ready", 128'(in_ready_a), 128'd1);
    chk("rst_out_valid", 128'(out_valid_a), 128'd0);
    chk("rst_out_data", out_data_a, 128'd0);
    chk("rst_busy", 128'(busy_a), 128'd0);
    chk("rst_out_data_std", out_data_b, 128'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    step();
    run(128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 4);
    run(128'hd4d4d4d5_2d26314c_00000000_ffffffff, 1'b0, 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff, 4);
    run(128'h0123456789abcdeffedcba9876543210, 1'b1, 128'h0123456789abcdeffedcba9876543210, 1);
    // backpressure with a competing request while stalled in DONE
    out_ready = 1'b0;
    in_data = {$urandom, $urandom, $urandom, $urandom}; in_bypass = 1'b0; in_valid = 1'b1;
    wait_ready("bp_accept_ready");
    step();
    in_valid = 1'b0;
    q.push_back(model(in_data, 1'b0));
    t = 0;
    while (!out_valid_a && t < 20) begin step(); t++; end
    chk("bp_reach_done", 128'(out_valid_a), 128'd1);
    snap = out_data_a;
    vnew = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin in_data = vnew; in_valid = 1'b1; end
      step();
      chk("bp_valid_hold", 128'(out_valid_a), 128'd1);
      chk("bp_data_hold", out_data_a, snap);
      chk("bp_no_accept", 128'(in_ready_a), 128'd0);
    end
    out_ready = 1'b1;
    step();
    chk("bp_idle", 128'(in_ready_a), 128'd1);
    step();
    in_valid = 1'b0;
    q.push_back(model(vnew, 1'b0));
    chk("bp_new_accepted", 128'(busy_a), 128'd1);
    t = 0;
    while (q.size() != 0 && t < 20) begin step(); t++; end
    chk("bp_drained", 128'(q.size()), 128'd0);
    // abort a transfer two columns in
    in_data = 128'hd4d4d4d5_2d26314c_00000000_ffffffff; in_valid = 1'b1;
    wait_ready("abort_ready");
    step();
    in_valid = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_in_ready", 128'(in_ready_a), 128'd1);
    chk("abort_out_valid", 128'(out_valid_a), 128'd0);
    chk("abort_out_data", out_data_a, 128'd0);
    chk("abort_busy", 128'(busy_a), 128'd0);
    step();
    chk("abort_no_output", 128'(out_valid_a), 128'd0);
    run(128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 4);
    // back-to-back with in_valid held high
    for (int i = 0; i < 3; i++) bb[i] = {$urandom, $urandom, $urandom, $urandom};
    in_bypass = 1'b0; in_valid = 1'b1; last = 0;
    for (int i = 0; i < 3; i++) begin
      in_data = bb[i];
      wait_ready("b2b_ready");
      if (i > 0) chk("b2b_interval", 128'(cyc - last), 128'd6);
      last = cyc;
      step();
      q.push_back(model(bb[i], 1'b0));
    end
    in_valid = 1'b0;
    t = 0;
    while (q.size() != 0 && t < 40) begin step(); t++; end
    chk("b2b_drained", 128'(q.size()), 128'd0);
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
